// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: symbol codes,
// active-low segment patterns ({g,f,e,d,c,b,a}) and the all-off values.
package ssd_pkg;

    // Symbol codes carried in each 5-bit digit field of the symbol word
    localparam logic [4:0] SYM_C     = 5'd10;
    localparam logic [4:0] SYM_L     = 5'd11;
    localparam logic [4:0] SYM_S     = 5'd12;
    localparam logic [4:0] SYM_D     = 5'd13;
    localparam logic [4:0] SYM_O     = 5'd14;
    localparam logic [4:0] SYM_P     = 5'd15;
    localparam logic [4:0] SYM_E     = 5'd16;
    localparam logic [4:0] SYM_N     = 5'd17;
    localparam logic [4:0] SYM_DASH  = 5'd18;
    localparam logic [4:0] SYM_BLANK = 5'd19;

    // Active-low segment patterns
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_S     = 7'h12;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/ssd_sym_decode.sv
// Combinational symbol-code to active-low segment pattern decoder.
// Unassigned codes (20..31) fall through to blank.
module ssd_sym_decode
    import ssd_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [6:0] o_seg
);

    // Table lookup, blank by default
    always_comb begin
        o_seg = SEG_OFF;
        case (i_code)
            5'd0:      o_seg = SEG_0;
            5'd1:      o_seg = SEG_1;
            5'd2:      o_seg = SEG_2;
            5'd3:      o_seg = SEG_3;
            5'd4:      o_seg = SEG_4;
            5'd5:      o_seg = SEG_5;
            5'd6:      o_seg = SEG_6;
            5'd7:      o_seg = SEG_7;
            5'd8:      o_seg = SEG_8;
            5'd9:      o_seg = SEG_9;
            SYM_C:     o_seg = SEG_C;
            SYM_L:     o_seg = SEG_L;
            SYM_S:     o_seg = SEG_S;
            SYM_D:     o_seg = SEG_D;
            SYM_O:     o_seg = SEG_O;
            SYM_P:     o_seg = SEG_P;
            SYM_E:     o_seg = SEG_E;
            SYM_N:     o_seg = SEG_N;
            SYM_DASH:  o_seg = SEG_DASH;
            default:   o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode scan driver. Each digit gets a slot of
// DIGIT_TICKS cycles whose first DEAD_CYC cycles keep all anodes off to
// stop ghosting. The symbol word and blink mask are latched into shadow
// registers only at frame boundaries so a frame never mixes old and new.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIGIT_TICKS = 50_000,
    parameter int DEAD_CYC    = 2,
    parameter int BLINK_HALF  = 25_000_000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] sym_in,
    input  logic [3:0]  blink_mask,
    input  logic        blink_sync,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam int TICK_W  = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int DEAD_W  = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [TICK_W-1:0]  r_tick_cnt;
    logic [1:0]         r_idx;
    logic [DEAD_W-1:0]  r_dead_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;
    logic [3:0][4:0]    r_shadow_sym;
    logic [3:0]         r_shadow_mask;
    logic               r_cap_pend;

    logic               w_tick_last;
    logic               w_blink_last;
    logic               w_capture;
    logic [6:0]         w_dec_seg;

    assign w_tick_last  = (r_tick_cnt == TICK_W'(DIGIT_TICKS - 1));
    assign w_blink_last = (r_blink_cnt == BLINK_W'(BLINK_HALF - 1));
    // Capture on the 3->0 wrap, or once right after reset so the display
    // does not sit on blanks for a whole frame.
    assign w_capture    = r_cap_pend | (w_tick_last & (r_idx == 2'd3));

    ssd_sym_decode u_dec (
        .i_code (r_shadow_sym[r_idx]),
        .o_seg  (w_dec_seg)
    );

    // Slot timing: tick counter, digit index and dead-time counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_idx      <= 2'd0;
            r_dead_cnt <= DEAD_W'(DEAD_CYC);
        end else if (w_tick_last) begin
            r_tick_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
            r_dead_cnt <= DEAD_W'(DEAD_CYC);
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            if (r_dead_cnt != '0)
                r_dead_cnt <= r_dead_cnt - DEAD_W'(1);
        end
    end

    // Blink half-period counter; sync wins over a coincident wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (blink_sync) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_blink_last) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // Frame-synchronous shadow capture of symbols and blink mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_sym  <= {4{SYM_BLANK}};
            r_shadow_mask <= 4'h0;
            r_cap_pend    <= 1'b1;
            frame_tick    <= 1'b0;
        end else begin
            frame_tick <= w_capture;
            r_cap_pend <= 1'b0;
            if (w_capture) begin
                r_shadow_sym  <= sym_in;
                r_shadow_mask <= blink_mask;
            end
        end
    end

    // Registered anode/segment drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (r_dead_cnt != '0) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= ~(4'b0001 << r_idx);
            seg <= (r_shadow_mask[r_idx] & r_phase) ? SEG_OFF : w_dec_seg;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboarded bench for ssd_scan_driver. The stimulus side predicts every
// cycle's outputs from the display rules (slot position from the cycle count,
// frame captures, blink phase from the last sync) and queues them; a monitor
// pops one entry per cycle and compares.
module tb_ssd_scan_driver;

    localparam int DT = 8;
    localparam int DC = 2;
    localparam int BH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] sym_in = {4{5'd19}};
    logic [3:0]  blink_mask = 4'h0;
    logic        blink_sync = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

    ssd_scan_driver #(.DIGIT_TICKS(DT), .DEAD_CYC(DC), .BLINK_HALF(BH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_in     (sym_in),
        .blink_mask (blink_mask),
        .blink_sync (blink_sync),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       ft;
        int         edge_no;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    bit          running = 1'b0;
    logic [6:0]  dec_tab [32];

    // Reference state: cycle count since reset release, shadowed display content
    int          t;
    int          base;
    logic [4:0]  m_sym [4];
    logic [3:0]  m_mask;

    function automatic void check(string name, int edge_no, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h expected=%h", name, edge_no, got, exp);
        end
    endfunction

    task automatic model_reset();
        t = 0;
        base = 0;
        for (int i = 0; i < 4; i++) m_sym[i] = 5'd19;
        m_mask = 4'h0;
        q.delete();
    endtask

    // Predict outputs that appear after clock edge t (from state after edge t-1)
    task automatic model_edge();
        exp_t e;
        int   s, idx, ph;
        t++;
        s   = t - 1;
        idx = (s / DT) % 4;
        ph  = ((s - base) / BH) % 2;
        e.edge_no = t;
        e.ft = (t == 1) || (t % (4 * DT) == 0);
        if ((s % DT) < DC) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
        end else begin
            e.an  = 4'hF ^ (4'b0001 << idx);
            e.seg = (m_mask[idx] && ph == 1) ? 7'h7F : dec_tab[m_sym[idx]];
        end
        q.push_back(e);
        if (e.ft) begin
            for (int i = 0; i < 4; i++) m_sym[i] = sym_in[i*5 +: 5];
            m_mask = blink_mask;
        end
        if (blink_sync) base = t;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            blink_sync = 1'b0;
        end
    endtask

    task automatic pulse_sync();
        blink_sync = 1'b1;
        run(1);
    endtask

    // Monitor: one expected entry per cycle while running
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (running) begin
                #1;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_underflow got=empty expected=entry");
                end else begin
                    e = q.pop_front();
                    check("an", e.edge_no, int'(an), int'(e.an));
                    check("seg", e.edge_no, int'(seg), int'(e.seg));
                    check("frame_tick", e.edge_no, int'(frame_tick), int'(e.ft));
                end
            end
        end
    end

    task automatic check_in_reset(string tag);
        check({tag, "_an"}, 0, int'(an), 4'hF);
        check({tag, "_seg"}, 0, int'(seg), 7'h7F);
        check({tag, "_ft"}, 0, int'(frame_tick), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        running = 1'b1;
    endtask

    initial begin
        logic [19:0] w;
        int guard;
        for (int i = 0; i < 32; i++) dec_tab[i] = 7'h7F;
        dec_tab[0]  = 7'h40; dec_tab[1]  = 7'h79; dec_tab[2]  = 7'h24; dec_tab[3]  = 7'h30;
        dec_tab[4]  = 7'h19; dec_tab[5]  = 7'h12; dec_tab[6]  = 7'h02; dec_tab[7]  = 7'h78;
        dec_tab[8]  = 7'h00; dec_tab[9]  = 7'h10; dec_tab[10] = 7'h46; dec_tab[11] = 7'h47;
        dec_tab[12] = 7'h12; dec_tab[13] = 7'h21; dec_tab[14] = 7'h40; dec_tab[15] = 7'h0C;
        dec_tab[16] = 7'h06; dec_tab[17] = 7'h2B; dec_tab[18] = 7'h3F;

        // Power-on reset
        repeat (3) @(negedge clk);
        check_in_reset("por");
        release_reset();

        // Blank shadow first, then {C,L,S,d} changed mid-frame
        run(40);
        sym_in = {5'd10, 5'd11, 5'd12, 5'd13};
        run(100);

        // Tearing: change while digit 2 is being scanned
        while (((t / DT) % 4) != 2) run(1);
        sym_in = {5'd7, 5'd8, 5'd9, 5'd0};
        run(70);

        // Blinking digit 3 showing '1', other digits blank
        sym_in = {5'd1, 5'd19, 5'd19, 5'd19};
        blink_mask = 4'b1000;
        run(300);

        // Sync pulsed while digit 3 is in its off half
        guard = 0;
        while (((t - base) / BH) % 2 != 1 && guard < 200) begin
            run(1);
            guard++;
        end
        run(10);
        pulse_sync();
        run(150);

        // Dash and out-of-table codes in digit 0
        blink_mask = 4'h0;
        sym_in = {5'd3, 5'd2, 5'd1, 5'd18};
        run(64);
        sym_in = {5'd3, 5'd2, 5'd1, 5'd20};
        run(64);
        sym_in = {5'd3, 5'd2, 5'd1, 5'd31};
        run(64);

        // Reset asserted mid-slot: outputs must go off immediately
        run(13);
        running = 1'b0;
        #2 rst = 1'b1;
        #1 check_in_reset("midslot");
        repeat (2) @(negedge clk);
        check_in_reset("held");
        sym_in = {5'd5, 5'd6, 5'd16, 5'd17};
        release_reset();

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                w = $urandom();
                sym_in = w;
            end
            if ($urandom_range(0, 3) == 0) blink_mask = 4'($urandom());
            if ($urandom_range(0, 7) == 0) pulse_sync();
            run($urandom_range(1, 40));
        end
        run(2);
        running = 1'b0;

        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard cycle budget so the run always ends
    initial begin
        #400000;
        $display("FAIL timeout got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
